// File: rtl/mips_multicycle_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_multicycle_sequencer: multi-cycle fetch/decode/exec/mem/wb control  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_multicycle_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [4:0]  rf_raddr1_o,
  output logic [4:0]  rf_raddr2_o,
  input  logic [31:0] rf_rdata1_i,
  input  logic [31:0] rf_rdata2_i,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [31:0] alu_din1_o,
  output logic [31:0] alu_din2_o,
  input  logic [31:0] alu_dout_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        illegal_o,
  output logic        bus_err_o,
  output logic        halted_o
);

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_LOAD  = 6'b000001;
  localparam logic [5:0] c_OP_STORE = 6'b000010;
  localparam logic [5:0] c_OP_JUMP  = 6'b000011;
  localparam logic [5:0] c_OP_HALT  = 6'b111111;
  localparam logic [3:0] c_ALU_ADD  = 4'b0000;
  localparam logic [3:0] c_ALU_ISEQ = 4'b0100;
  localparam logic [3:0] c_ALU_ISLT = 4'b0101;
  localparam logic [3:0] c_ALU_ISGT = 4'b1100;
  localparam int unsigned c_CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q;
  logic [31:0]     pc_q;
  logic [31:0]     ir_q;
  logic [31:0]     b_q;
  logic [c_CW-1:0] cnt_q;

  logic [5:0]  op_d;
  logic [4:0]  rdst_d;
  logic [15:0] imm_d;
  logic [31:0] sext_d;
  logic [31:0] pc4_d;
  logic [31:0] exec_pc_d;
  logic [3:0]  ctrl_d;
  logic [31:0] din1_d;
  logic [31:0] din2_d;
  logic        illegal_d;
  logic        is_branch_d;
  logic        taken_d;
  logic        wait_d;

  function automatic logic fn_bad(input logic [3:0] f);
    return (f == 4'b0011) || (f == 4'b0110) || (f == 4'b0111) || (f == 4'b1101);
  endfunction

  assign op_d        = ir_q[31:26];
  assign rdst_d      = ir_q[25:21];
  assign imm_d       = ir_q[15:0];
  assign sext_d      = {{16{imm_d[15]}}, imm_d};
  assign pc4_d       = pc_q + 32'd4;
  assign is_branch_d = (op_d[5:3] == 3'b001);
  // bneq/bnez invert in the low half of the branch group, bgez/blez in the high half
  assign taken_d     = (alu_dout_i != 32'd0) ^ (op_d[2] ? op_d[1] : op_d[0]);
  assign wait_d      = (imem_req_o & ~imem_ack_i) | (dmem_req_o & ~dmem_ack_i);

  always_comb begin
    ctrl_d    = c_ALU_ADD;
    din1_d    = rf_rdata1_i;
    din2_d    = rf_rdata2_i;
    illegal_d = 1'b0;
    if (op_d == c_OP_RTYPE) begin
      ctrl_d    = ir_q[3:0];
      illegal_d = fn_bad(ir_q[3:0]);
      if (ir_q[3:1] == 3'b111) din2_d = {28'b0, ir_q[10:7]};
    end else if (op_d[5:4] == 2'b01) begin
      ctrl_d    = op_d[3:0];
      illegal_d = fn_bad(op_d[3:0]);
      if (op_d[3:1] == 3'b111)      din2_d = {27'b0, imm_d[4:0]};
      else if (op_d[3:2] == 2'b10)  din2_d = {16'b0, imm_d};
      else                          din2_d = sext_d;
    end else if (is_branch_d) begin
      ctrl_d = op_d[2] ? (op_d[0] ? c_ALU_ISGT : c_ALU_ISLT) : c_ALU_ISEQ;
      if (op_d[1]) din2_d = 32'd0;
    end else if (op_d == c_OP_LOAD || op_d == c_OP_STORE) begin
      din2_d = sext_d;
    end else if (op_d != c_OP_JUMP && op_d != c_OP_HALT) begin
      illegal_d = 1'b1;
    end
  end

  always_comb begin
    exec_pc_d = pc4_d;
    if (op_d == c_OP_JUMP)          exec_pc_d = {4'b0, ir_q[25:0], 2'b00};
    else if (is_branch_d && taken_d) exec_pc_d = {16'b0, imm_d[15:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= 32'd0;
      b_q          <= 32'd0;
      cnt_q        <= '0;
      imem_req_o   <= 1'b0;
      imem_addr_o  <= 32'd0;
      rf_raddr1_o  <= 5'd0;
      rf_raddr2_o  <= 5'd0;
      rf_we_o      <= 1'b0;
      rf_waddr_o   <= 5'd0;
      rf_wdata_o   <= 32'd0;
      alu_ctrl_o   <= 4'd0;
      alu_din1_o   <= 32'd0;
      alu_din2_o   <= 32'd0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_wdata_o <= 32'd0;
      illegal_o    <= 1'b0;
      bus_err_o    <= 1'b0;
      halted_o     <= 1'b0;
    end else begin
      illegal_o <= 1'b0;
      rf_we_o   <= 1'b0;
      if (wait_d && cnt_q == c_CNT_LAST) begin
        imem_req_o <= 1'b0;
        dmem_req_o <= 1'b0;
        dmem_we_o  <= 1'b0;
        bus_err_o  <= 1'b1;
        halted_o   <= 1'b1;
        cnt_q      <= '0;
        state_q    <= S_HALT;
      end else begin
        cnt_q <= wait_d ? cnt_q + c_CW'(1) : '0;
        case (state_q)
          S_FETCH: begin
            if (!imem_req_o) begin
              imem_req_o  <= 1'b1;
              imem_addr_o <= pc_q;
            end else if (imem_ack_i) begin
              imem_req_o  <= 1'b0;
              ir_q        <= imem_rdata_i;
              rf_raddr1_o <= imem_rdata_i[20:16];
              rf_raddr2_o <= (imem_rdata_i[31:26] == c_OP_STORE) ? imem_rdata_i[25:21]
                                                                 : imem_rdata_i[15:11];
              state_q     <= S_DECODE;
            end
          end
          S_DECODE: begin
            b_q        <= rf_rdata2_i;
            alu_ctrl_o <= ctrl_d;
            alu_din1_o <= din1_d;
            alu_din2_o <= din2_d;
            illegal_o  <= illegal_d;
            state_q    <= S_EXEC;
          end
          S_EXEC: begin
            if (illegal_d || is_branch_d || op_d == c_OP_JUMP) begin
              pc_q        <= exec_pc_d;
              imem_addr_o <= exec_pc_d;
              imem_req_o  <= 1'b1;
              state_q     <= S_FETCH;
            end else if (op_d == c_OP_HALT) begin
              halted_o <= 1'b1;
              state_q  <= S_HALT;
            end else if (op_d == c_OP_LOAD || op_d == c_OP_STORE) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= (op_d == c_OP_STORE);
              dmem_addr_o  <= alu_dout_i;
              dmem_wdata_o <= b_q;
              state_q      <= S_MEM;
            end else begin
              rf_we_o    <= (rdst_d != 5'd0);
              rf_waddr_o <= rdst_d;
              rf_wdata_o <= alu_dout_i;
              state_q    <= S_WB;
            end
          end
          S_MEM: begin
            if (dmem_ack_i) begin
              dmem_req_o <= 1'b0;
              dmem_we_o  <= 1'b0;
              if (dmem_we_o) begin
                pc_q        <= pc4_d;
                imem_addr_o <= pc4_d;
                imem_req_o  <= 1'b1;
                state_q     <= S_FETCH;
              end else begin
                rf_we_o    <= (rdst_d != 5'd0);
                rf_waddr_o <= rdst_d;
                rf_wdata_o <= dmem_rdata_i;
                state_q    <= S_WB;
              end
            end
          end
          S_WB: begin
            pc_q        <= pc4_d;
            imem_addr_o <= pc4_d;
            imem_req_o  <= 1'b1;
            state_q     <= S_FETCH;
          end
          default: state_q <= S_HALT;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
